// File: rtl/seq_mult_32b.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock.
// Signed operation multiplies magnitudes and negates the 2*WIDTH result at the end.
module seq_mult_32b #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] final_val;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt == CNT_W'(WIDTH - 1)) state_d = SIGN;
      SIGN: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Magnitude of the most negative value wraps to itself, which is correct as unsigned.
  always_comb begin
    mag_a     = (is_signed && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    mag_b     = (is_signed && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    final_val = neg ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      neg        <= 1'b0;
      acc        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          // The carry out of the upper-half add shifts into the top bit.
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        SIGN: begin
          {product_hi, product_lo} <= final_val;
          done <= 1'b1;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_32b.sv
// Directed checks of the sequential multiplier: products, latency, start handling, reset.
module tb_seq_mult_32b;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  seq_mult_32b #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Launch one operation and follow it for 40 edges; done must be seen only after edge 33.
  task automatic mult(input string tag, input logic s, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] exp);
    int unsigned pulses;
    int unsigned first;
    pulses = 0;
    first  = 0;
    @(negedge clk);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    chk({tag, "_busy_up"}, 64'(busy), 64'd1);
    start = 1'b0; op_a = ~a; op_b = ~b; is_signed = ~s;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk({tag, "_done_edge"}, 64'(first), 64'd33);
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_product"}, {product_hi, product_lo}, exp);
    chk({tag, "_busy_down"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int unsigned pulses;
    int unsigned d1;
    int unsigned d2;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    mult("u3x5",     1'b0, 32'd3,        32'd5,        64'h00000000_0000000F);
    mult("s_m2x3",   1'b1, 32'hFFFFFFFE, 32'd3,        64'hFFFFFFFF_FFFFFFFA);
    mult("u_ffxff",  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    mult("s_m1xm1",  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    mult("s_minsq",  1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    mult("s_minx1",  1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000);
    mult("zero",     1'b0, 32'd0,        32'h12345,    64'd0);

    // Start while busy is ignored; prior product stays visible during the new run.
    pulses = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_product", {product_hi, product_lo}, 64'd0);
    for (int i = 1; i <= 40; i++) begin
      if (i == 10) begin
        @(negedge clk);
        start = 1'b1; op_a = 32'd2; op_b = 32'd2;
      end
      @(posedge clk); #1;
      if (i == 10) start = 1'b0;
      if (done) pulses++;
    end
    chk("busy_ignore_pulses", 64'(pulses), 64'd1);
    chk("busy_ignore_product", {product_hi, product_lo}, 64'h3F);
    mult("u2x2", 1'b0, 32'd2, 32'd2, 64'd4);

    // Start held high: relaunch on the first IDLE edge after DONE.
    pulses = 0; d1 = 0; d2 = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    for (int i = 1; i <= 69; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (d1 == 0) d1 = i;
        else d2 = i;
      end
    end
    start = 1'b0;
    chk("hold_pulses", 64'(pulses), 64'd2);
    chk("hold_first", 64'(d1), 64'd33);
    chk("hold_second", 64'(d2), 64'd68);
    chk("hold_product", {product_hi, product_lo}, 64'd30);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start = 1'b1; op_a = 32'h1234; op_b = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_product", {product_hi, product_lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("arst_no_done", 64'(pulses), 64'd0);
    chk("arst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
